// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage: main output register plus optional skid entry.
// Skid entry and registered o_ready are enabled by defining PIPE_STAGE_SKID_EN.
//
// state    | meaning
// ST_EMPTY | no entry held, o_valid low
// ST_ONE   | main register holds the oldest entry, skid empty
// ST_TWO   | main and skid both hold entries, o_ready low (skid build only)
module pipe_stage_reg #(
  parameter int DATA_W         = 32,
  parameter bit CLEAR_ON_FLUSH = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_flush,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_flushed,
  output logic [1:0]        o_count
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic              flushed_q;
  logic              ready;
  logic              accept;
  logic              emit;

`ifdef PIPE_STAGE_SKID_EN
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              ready_q;

  // Ready is a flop so i_ready never reaches o_ready combinationally.
  assign ready = ready_q;
`else
  assign ready = (state_q == ST_EMPTY) || i_ready;
`endif

  assign o_valid   = (state_q != ST_EMPTY);
  assign o_data    = main_q;
  assign o_ready   = ready;
  assign o_flushed = flushed_q;
  assign o_count   = {state_q == ST_TWO, state_q == ST_ONE};

  assign accept = i_valid && ready;
  assign emit   = o_valid && i_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
`ifdef PIPE_STAGE_SKID_EN
    skid_d  = skid_q;
`endif
    if (i_flush) begin
      state_d = ST_EMPTY;
      if (CLEAR_ON_FLUSH) begin
        main_d = '0;
`ifdef PIPE_STAGE_SKID_EN
        skid_d = '0;
`endif
      end
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            main_d  = i_data;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && emit) begin
            main_d = i_data;
          end else if (emit) begin
            state_d = ST_EMPTY;
`ifdef PIPE_STAGE_SKID_EN
          end else if (accept) begin
            skid_d  = i_data;
            state_d = ST_TWO;
`endif
          end
        end
`ifdef PIPE_STAGE_SKID_EN
        ST_TWO: begin
          if (emit) begin
            main_d  = skid_q;
            state_d = ST_ONE;
          end
        end
`endif
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q   <= ST_EMPTY;
      main_q    <= '0;
      flushed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      main_q    <= main_d;
      flushed_q <= i_flush;
    end
  end

`ifdef PIPE_STAGE_SKID_EN
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      skid_q  <= '0;
      ready_q <= 1'b1;
    end else begin
      skid_q  <= skid_d;
      ready_q <= (state_d != ST_TWO);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed vector bench for pipe_stage_reg; expectations follow PIPE_STAGE_SKID_EN.
module tb_pipe_stage_reg;

  logic        i_clk;
  logic        i_reset;
  logic        i_flush;
  logic        i_valid;
  logic [31:0] i_data;
  logic        i_ready;
  logic        o_ready,   nc_ready;
  logic        o_valid,   nc_valid;
  logic [31:0] o_data,    nc_data;
  logic        o_flushed, nc_flushed;
  logic [1:0]  o_count,   nc_count;

  int tests = 0;
  int fails = 0;

  pipe_stage_reg #(.DATA_W(32), .CLEAR_ON_FLUSH(1'b1)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_flush(i_flush), .i_valid(i_valid),
    .o_ready(o_ready), .i_data(i_data), .o_valid(o_valid), .i_ready(i_ready),
    .o_data(o_data), .o_flushed(o_flushed), .o_count(o_count)
  );

  pipe_stage_reg #(.DATA_W(32), .CLEAR_ON_FLUSH(1'b0)) dut_nc (
    .i_clk(i_clk), .i_reset(i_reset), .i_flush(i_flush), .i_valid(i_valid),
    .o_ready(nc_ready), .i_data(i_data), .o_valid(nc_valid), .i_ready(i_ready),
    .o_data(nc_data), .o_flushed(nc_flushed), .o_count(nc_count)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        f;
    logic        v;
    logic [31:0] d;
    logic        r;
    logic        e_rdy;
    logic        e_vld;
    logic [31:0] e_data;
    logic        chk_d;
    logic [1:0]  e_cnt;
    logic        e_fl;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic f, v, input logic [31:0] d, input logic r,
                     input logic e_rdy, e_vld, input logic [31:0] e_data,
                     input logic chk_d, input logic [1:0] e_cnt, input logic e_fl);
    vec_t t;
    t.f = f; t.v = v; t.d = d; t.r = r;
    t.e_rdy = e_rdy; t.e_vld = e_vld; t.e_data = e_data; t.chk_d = chk_d;
    t.e_cnt = e_cnt; t.e_fl = e_fl;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive at the falling edge, then return 1ns after the next rising edge.
  task automatic step(input logic f, v, input logic [31:0] d, input logic r);
    @(negedge i_clk);
    i_flush = f; i_valid = v; i_data = d; i_ready = r;
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    i_reset = 1'b1; i_flush = 1'b0; i_valid = 1'b0; i_data = '0; i_ready = 1'b0;
    #2 i_reset = 1'b0;
    #1;
    chk("rst_valid",   32'(o_valid),   32'd0);
    chk("rst_data",    o_data,         32'd0);
    chk("rst_count",   32'(o_count),   32'd0);
    chk("rst_flushed", 32'(o_flushed), 32'd0);
    chk("rst_ready",   32'(o_ready),   32'd1);
    @(negedge i_clk);
    i_reset = 1'b1;

    //   f  v  data    r  rdy vld e_data  chk cnt fl
    add(0, 1, 32'h1,  1, 1,  1,  32'h1,  1,  1,  0);
    add(0, 1, 32'h2,  1, 1,  1,  32'h2,  1,  1,  0);
    add(0, 1, 32'h3,  1, 1,  1,  32'h3,  1,  1,  0);
    add(0, 0, 32'h0,  1, 1,  0,  32'h0,  0,  0,  0);
    add(1, 1, 32'h99, 1, 1,  0,  32'h0,  1,  0,  1);
    add(0, 1, 32'hA,  0, 1,  1,  32'hA,  1,  1,  0);
`ifdef PIPE_STAGE_SKID_EN
    add(0, 1, 32'hB,  0, 1,  1,  32'hA,  1,  2,  0);
    add(0, 1, 32'hC,  0, 0,  1,  32'hA,  1,  2,  0);
    add(0, 0, 32'h0,  1, 0,  1,  32'hB,  1,  1,  0);
    add(0, 0, 32'h0,  1, 1,  0,  32'h0,  0,  0,  0);
    add(0, 1, 32'hA,  0, 1,  1,  32'hA,  1,  1,  0);
    add(0, 1, 32'hB,  0, 1,  1,  32'hA,  1,  2,  0);
    add(1, 1, 32'hC,  1, 0,  0,  32'h0,  1,  0,  1);
    add(0, 0, 32'h0,  1, 1,  0,  32'h0,  1,  0,  0);
    add(0, 1, 32'h21, 1, 1,  1,  32'h21, 1,  1,  0);
    add(0, 1, 32'h22, 1, 1,  1,  32'h22, 1,  1,  0);
    add(0, 0, 32'h0,  0, 1,  1,  32'h22, 1,  1,  0);
    add(0, 1, 32'h23, 0, 1,  1,  32'h22, 1,  2,  0);
    add(0, 1, 32'h24, 1, 0,  1,  32'h23, 1,  1,  0);
    add(0, 1, 32'h25, 1, 1,  1,  32'h25, 1,  1,  0);
    add(0, 0, 32'h0,  1, 1,  0,  32'h0,  0,  0,  0);
`else
    add(0, 1, 32'hB,  0, 0,  1,  32'hA,  1,  1,  0);
    add(0, 1, 32'hB,  1, 1,  1,  32'hB,  1,  1,  0);
    add(0, 1, 32'hC,  1, 1,  1,  32'hC,  1,  1,  0);
    add(0, 0, 32'h0,  0, 0,  1,  32'hC,  1,  1,  0);
    add(1, 1, 32'hD,  0, 0,  0,  32'h0,  1,  0,  1);
    add(0, 0, 32'h0,  0, 1,  0,  32'h0,  1,  0,  0);
    add(0, 1, 32'h21, 1, 1,  1,  32'h21, 1,  1,  0);
    add(0, 0, 32'h0,  1, 1,  0,  32'h0,  0,  0,  0);
`endif

    foreach (vecs[i]) begin
      @(negedge i_clk);
      i_flush = vecs[i].f; i_valid = vecs[i].v; i_data = vecs[i].d; i_ready = vecs[i].r;
      #1;
      chk($sformatf("v%0d_ready", i), 32'(o_ready), 32'(vecs[i].e_rdy));
      @(posedge i_clk);
      #1;
      chk($sformatf("v%0d_valid", i),   32'(o_valid),   32'(vecs[i].e_vld));
      chk($sformatf("v%0d_count", i),   32'(o_count),   32'(vecs[i].e_cnt));
      chk($sformatf("v%0d_flushed", i), 32'(o_flushed), 32'(vecs[i].e_fl));
      if (vecs[i].chk_d) chk($sformatf("v%0d_data", i), o_data, vecs[i].e_data);
    end

    // Flush without clearing keeps the payload; back-to-back flushes hold o_flushed.
    step(0, 1, 32'h55, 0);
    chk("nc_load_data", nc_data, 32'h55);
    step(1, 0, 32'h0, 0);
    chk("nc_flush_valid", 32'(nc_valid), 32'd0);
    chk("nc_flush_data",  nc_data,       32'h55);
    chk("clr_flush_data", o_data,        32'h0);
    chk("flush1_flushed", 32'(o_flushed), 32'd1);
    step(1, 0, 32'h0, 0);
    chk("flush2_flushed", 32'(o_flushed), 32'd1);
    chk("flush2_nc_data", nc_data,       32'h55);
    step(0, 0, 32'h0, 0);
    chk("flush3_flushed", 32'(o_flushed), 32'd0);

    // Asynchronous reset between edges while entries are held.
    step(0, 1, 32'hA, 0);
    step(0, 1, 32'hB, 0);
`ifdef PIPE_STAGE_SKID_EN
    chk("pre_rst_count", 32'(o_count), 32'd2);
`else
    chk("pre_rst_count", 32'(o_count), 32'd1);
`endif
    @(negedge i_clk);
    i_valid = 1'b0; i_ready = 1'b0;
    #2 i_reset = 1'b0;
    #1;
    chk("arst_valid", 32'(o_valid), 32'd0);
    chk("arst_data",  o_data,       32'd0);
    chk("arst_count", 32'(o_count), 32'd0);
    chk("arst_ready", 32'(o_ready), 32'd1);
    chk("arst_nc_data", nc_data,    32'd0);
    @(negedge i_clk);
    i_reset = 1'b1;
    step(0, 1, 32'h7, 0);
    chk("post_rst_valid", 32'(o_valid), 32'd1);
    chk("post_rst_data",  o_data,       32'h7);
    chk("post_rst_count", 32'(o_count), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 32: width of the payload carried by the stage.
REQ-002 Parameter CLEAR_ON_FLUSH, default 1: 1 = payload registers zeroed on flush; 0 = payload left unchanged, valid cleared only.
REQ-003 Port i_clk  input  1  clock; all state updates on rising edge.
REQ-004 Port i_reset  input  1  asynchronous, active-low reset.
REQ-005 Port i_flush  input  1  synchronous kill of all held and incoming entries.
REQ-006 Port i_valid  input  1  upstream entry present.
REQ-007 Port o_ready  output  1  stage can accept an entry this cycle.
REQ-008 Port i_data  input  DATA_W  upstream payload.
REQ-009 Port o_valid  output  1  downstream entry present.
REQ-010 Port i_ready  input  1  downstream accepts this cycle.
REQ-011 Port o_data  output  DATA_W  downstream payload.
REQ-012 Port o_flushed  output  1  one-cycle pulse marking the cycle after a flush.
REQ-013 Port o_count  output  2  entries currently held (0..2).

Function
REQ-014 Accept occurs when i_valid && o_ready; emit occurs when o_valid && i_ready.
REQ-015 Latency: an entry accepted in cycle N is presented on o_valid/o_data in cycle N+1 at the earliest.
REQ-016 Storage: main register (drives o_data/o_valid) plus one skid register; entries emitted strictly in accept order.
REQ-017 Empty (count 0): accept loads main; o_valid=1 next cycle.
REQ-018 Count 1, emit without accept: main empties; count 0.
REQ-019 Count 1, accept and emit same cycle: main loads i_data; count stays 1, no bubble.
REQ-020 Count 1, accept without emit: i_data loads skid; count 2.
REQ-021 Count 2: o_ready=0; on emit, skid moves to main; count 1.
REQ-022 o_data and o_valid SHALL hold stable while o_valid && !i_ready.
REQ-023 o_ready SHALL be driven from a register (no combinational path from i_ready) when skid enabled.
REQ-024 i_flush has priority over accept and emit: next cycle count=0, o_valid=0, skid empty; the incoming entry that cycle is dropped; no emit is counted.
REQ-025 On flush with CLEAR_ON_FLUSH=1, main and skid payload registers SHALL become all-zero; with 0, payload unchanged.
REQ-026 o_flushed SHALL be 1 in the cycle after any cycle with i_flush=1, else 0; back-to-back flushes hold it at 1.
REQ-027 o_count SHALL equal the number of valid entries (main + skid) at all times.

Reset
REQ-028 i_reset low SHALL immediately force o_valid=0, o_data=0, skid cleared, o_count=0, o_flushed=0, o_ready=1.
REQ-029 Reset mid-transfer discards all entries; first accept after release behaves as REQ-017.

Configuration
REQ-030 Macro PIPE_STAGE_SKID_EN defined: skid register present, behaviour per REQ-016..REQ-023, full throughput with registered o_ready.
REQ-031 Macro PIPE_STAGE_SKID_EN undefined: no skid register; o_ready = !o_valid || i_ready (combinational); o_count never exceeds 1; REQ-020/021/023 not applicable; all other requirements unchanged.

Verification
REQ-032 Streaming: DATA_W=32, i_ready=1, i_valid=1 with data 0x1,0x2,0x3 on cycles 1-3 -> o_data 0x1,0x2,0x3 on cycles 2-4, o_valid continuous, o_count=1.
REQ-033 Backpressure (skid on): i_ready=0, accept 0xA then 0xB -> o_count=2, o_ready=0, o_data holds 0xA; i_ready=1 -> 0xA then 0xB emitted, o_ready=1 after first emit.
REQ-034 Flush: count=2 holding 0xA,0xB, i_flush=1 with i_valid=1 data 0xC -> next cycle o_valid=0, o_count=0, o_data=0, o_flushed=1; following cycle o_flushed=0; 0xC never emitted.
REQ-035 Flush with CLEAR_ON_FLUSH=0: main holds 0x55 -> after flush o_valid=0, o_data=0x55.
REQ-036 Async reset: assert i_reset low between clock edges with count=2 -> outputs reach reset values before the next edge; accept 0x7 after release -> o_data=0x7 one cycle later.
REQ-037 Skid disabled build: i_ready=0 with o_valid=1 -> o_ready=0 same cycle; i_ready=1 -> o_ready=1 same cycle, one accept and one emit per cycle.
